// File: rtl/note_judge_pkg.sv
// note_judge_pkg: shared definitions for the note highway judge.
//  - NUM_FRETS    : width of a chart row / fret bank
//  - EIGHTH_NOTE  : clk cycles per eighth note, shared with the rate driver
//  - state_e      : judge FSM states
//  - verdict_e    : per-row outcome
//  - sat_inc8     : saturating 8-bit increment used by the streak counter
package note_judge_pkg;

    localparam int NUM_FRETS   = 5;
    localparam int EIGHTH_NOTE = 13157894;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WINDOW,
        S_JUDGE
    } state_e;

    typedef enum logic [1:0] {
        V_NONE,
        V_HIT,
        V_MISS
    } verdict_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/note_judge_strum_debounce.sv
// strum_debounce: counter-based level filter for the synchronized strum.
//  The output follows the input only after the input has differed from the
//  output for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts.
//  Ports:
//   clk    in  clock
//   resetn in  asynchronous reset, active low
//   din    in  synchronized raw level
//   dout   out filtered level
module strum_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/note_judge.sv
// note_judge: scores fret+strum input against the chart row at the judge line.
//  A row latched on beat stays judgeable for WINDOW_CYCLES cycles. A strum
//  rise inside the window judges it (hit only on an exact, non-empty chord);
//  a timeout or a following beat resolves it as a miss (or nothing for an
//  empty row). Strums outside any window are overstrums and count as misses.
//  Optional macro NOTE_JUDGE_DEBOUNCE_EN inserts strum_debounce on the strum
//  path; without it strum_rise comes straight from the 2-flop synchronizer.
//  Ports:
//   clk, resetn           clock, async active-low reset
//   beat                  one-cycle row pulse from the rate driver
//   notes_to_play[4:0]    chart row, valid in the beat cycle
//   frets[4:0], strum     raw buttons (synchronized here)
//   pause, stop           levels: freeze judging / abort current row
//   correct_notes[4:0]    pulse: row bits hit
//   hit, miss             pulse: row verdict
//   score[15:0]           saturating score
//   streak[7:0]           saturating consecutive hits
//   multiplier[2:0]       1..MAX_MULT
module note_judge
    import note_judge_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES   = 6578947,
    parameter int unsigned HIT_POINTS      = 10,
    parameter int unsigned STREAK_STEP     = 10,
    parameter int unsigned MAX_MULT        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 beat,
    input  logic [NUM_FRETS-1:0] notes_to_play,
    input  logic [NUM_FRETS-1:0] frets,
    input  logic                 strum,
    input  logic                 pause,
    input  logic                 stop,
    output logic [NUM_FRETS-1:0] correct_notes,
    output logic                 hit,
    output logic                 miss,
    output logic [15:0]          score,
    output logic [7:0]           streak,
    output logic [2:0]           multiplier
);

    localparam int unsigned WCW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    // ---------------- input synchronizers ----------------
    logic [1:0][NUM_FRETS-1:0] fret_sync;
    logic [1:0]                strum_sync;
    logic                      strum_lvl;
    logic                      strum_prev;
    logic                      strum_rise;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fret_sync  <= '0;
            strum_sync <= '0;
            strum_prev <= 1'b0;
        end else begin
            fret_sync  <= {fret_sync[0], frets};
            strum_sync <= {strum_sync[0], strum};
            // Keeps tracking during pause so a press made while paused
            // does not fire as a stale edge on release.
            strum_prev <= strum_lvl;
        end
    end

`ifdef NOTE_JUDGE_DEBOUNCE_EN
    strum_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_strum_debounce (
        .clk    (clk),
        .resetn (resetn),
        .din    (strum_sync[1]),
        .dout   (strum_lvl)
    );
`else
    assign strum_lvl = strum_sync[1];
`endif

    assign strum_rise = strum_lvl & ~strum_prev;

    // ---------------- judge FSM ----------------
    state_e               state, state_d;
    logic [NUM_FRETS-1:0] expected, expected_d;
    logic [WCW-1:0]       wcnt, wcnt_d;
    verdict_e             verdict;
    logic                 last_cycle;
    logic                 row_hit;

    assign last_cycle = (wcnt == WCW'(WINDOW_CYCLES - 1));
    assign row_hit    = (expected != '0) && (fret_sync[1] == expected);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            expected <= '0;
            wcnt     <= '0;
        end else begin
            state    <= state_d;
            expected <= expected_d;
            wcnt     <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        expected_d = expected;
        wcnt_d     = wcnt;
        verdict    = V_NONE;
        if (stop) begin
            state_d    = S_IDLE;
            expected_d = '0;
            wcnt_d     = '0;
        end else if (!pause) begin
            unique case (state)
                S_IDLE: begin
                    if (strum_rise) verdict = V_MISS;   // overstrum
                    if (beat) begin
                        state_d    = S_WINDOW;
                        expected_d = notes_to_play;
                        wcnt_d     = '0;
                    end
                end
                S_WINDOW: begin
                    // A strum always judges the current row, even when a new
                    // beat arrives in the same cycle; otherwise a beat or the
                    // last window cycle resolves it as a timeout.
                    if (strum_rise)
                        verdict = row_hit ? V_HIT : V_MISS;
                    else if (beat || last_cycle)
                        verdict = (expected != '0) ? V_MISS : V_NONE;
                    if (beat) begin
                        expected_d = notes_to_play;
                        wcnt_d     = '0;
                    end else if (strum_rise || last_cycle) begin
                        state_d = S_JUDGE;
                    end else begin
                        wcnt_d = wcnt + 1'b1;
                    end
                end
                S_JUDGE: begin
                    if (beat) begin
                        state_d    = S_WINDOW;
                        expected_d = notes_to_play;
                        wcnt_d     = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- scoring ----------------
    function automatic logic [2:0] mult_of(input logic [7:0] s);
        int unsigned steps;
        steps = 32'(s) / STREAK_STEP + 1;
        return (steps >= MAX_MULT) ? 3'(MAX_MULT) : 3'(steps);
    endfunction

    logic                 hit_d, miss_d;
    logic [NUM_FRETS-1:0] correct_d;
    logic [15:0]          score_d;
    logic [7:0]           streak_d;
    logic [2:0]           mult_d;
    logic [16:0]          sum;

    always_comb begin
        hit_d     = (verdict == V_HIT);
        miss_d    = (verdict == V_MISS);
        correct_d = hit_d ? expected : '0;
        score_d   = score;
        streak_d  = streak;
        mult_d    = multiplier;
        // Points use the multiplier in force before this hit.
        sum       = {1'b0, score} + 17'(HIT_POINTS) * 17'(multiplier);
        if (hit_d) begin
            score_d  = sum[16] ? 16'hFFFF : sum[15:0];
            streak_d = sat_inc8(streak);
            mult_d   = mult_of(streak_d);
        end else if (miss_d) begin
            streak_d = '0;
            mult_d   = 3'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit           <= 1'b0;
            miss          <= 1'b0;
            correct_notes <= '0;
            score         <= '0;
            streak        <= '0;
            multiplier    <= 3'd1;
        end else begin
            hit           <= hit_d;
            miss          <= miss_d;
            correct_notes <= correct_d;
            score         <= score_d;
            streak        <= streak_d;
            multiplier    <= mult_d;
        end
    end

endmodule
